// File: rtl/register_12bit_pkg.sv
// Shared constants for the 12-bit data register.
package register_12bit_pkg;

  // Data path width; the register is only ever built 12 bits wide.
  localparam int WIDTH_DEFAULT = 12;

  // Value forced onto data_out by a reset edge.
  localparam logic [11:0] RESET_VALUE_DEFAULT = 12'h000;

endpackage : register_12bit_pkg

// File: rtl/register_12bit_dff_sync_rstn.sv
// Single-bit D flop with synchronous active-low reset.
// It is the building block that the 12-bit register is made from.
module dff_sync_rstn
  import register_12bit_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  // Next state: every non-reset edge loads d. There is no enable.
  always_comb begin
    q_d = d;
  end

  // Storage flop. Reset is sampled only at the rising edge, so dropping rst between edges has no effect until the next edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : dff_sync_rstn

// File: rtl/register_12bit.sv
// 12-bit pipeline register with synchronous active-low reset.
// It is built from one reset flop per bit, so data_out comes straight from flops.
module register_12bit
  import register_12bit_pkg::*;
#(
  parameter int             WIDTH       = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = RESET_VALUE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // One flop per bit. Bit i of RESET_VALUE sets the reset state of bit i, so no bit depends on any other bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync_rstn #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (data_in[i]),
      .q   (data_out[i])
    );
  end

endmodule : register_12bit

// File: tb/tb_register_12bit.sv
// Self-checking bench for register_12bit: directed cases followed by random data and reset.
module tb_register_12bit;

  logic        clk;
  logic        rst;
  logic [11:0] data_in;
  logic [11:0] data_out;

  int total;
  int bad;

  // Reference model state: the value data_out should show after the latest rising edge.
  logic [11:0] model_out;

  register_12bit dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour at one edge: reset wins, otherwise data_in is captured.
  function automatic logic [11:0] model_edge(input logic r, input logic [11:0] din);
    return r ? din : 12'h000;
  endfunction

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next rising edge, update the model, and sample 1 unit later.
  task automatic edge_and_check(input string tag);
    @(posedge clk);
    model_out = model_edge(rst, data_in);
    #1;
    check_val(tag, data_out, model_out);
  endtask

  // Main stimulus: directed steps first, then a random run.
  initial begin
    logic [31:0] r;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    data_in   = 12'hFFF;
    model_out = 12'h000;

    // Reset edge while data_in is all ones.
    edge_and_check("reset");

    // Load 12'hA5C. The output must not change before the edge.
    @(negedge clk);
    rst     = 1'b1;
    data_in = 12'hA5C;
    #1;
    check_val("load_before_edge", data_out, 12'h000);
    edge_and_check("load_a5c");

    // Hold: data_in changes twice between edges, and only the last value is captured.
    @(negedge clk);
    data_in = 12'h123;
    #1;
    check_val("hold_first_change", data_out, 12'hA5C);
    data_in = 12'h456;
    #1;
    check_val("hold_second_change", data_out, 12'hA5C);
    edge_and_check("hold_capture_456");

    // Synchronous reset timing: rst drops mid-cycle while data_out is 12'h7E1.
    @(negedge clk);
    data_in = 12'h7E1;
    edge_and_check("load_7e1");
    @(negedge clk);
    rst     = 1'b0;
    data_in = 12'h3C3;
    #1;
    check_val("reset_mid_cycle_hold", data_out, 12'h7E1);
    edge_and_check("reset_at_edge");

    // Release: the first edge after release loads data_in.
    @(negedge clk);
    rst     = 1'b1;
    data_in = 12'h800;
    edge_and_check("release_800");

    // Random run: glitch data_in between edges, and assert reset about 1/4 of the time.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r       = $urandom;
      data_in = r[11:0];
      rst     = (r[31:30] != 2'b00);
      #1;
      check_val("random_hold", data_out, model_out);
      r       = $urandom;
      data_in = r[11:0];
      edge_and_check("random_edge");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_12bit

// File: doc/register_12bit.md
REGISTER_12BIT -- requirements
Module: register_12bit

Interface
REQ-001 Parameter: WIDTH, default 12, data path width in bits; the only legal value for this block is 12.
REQ-002 Parameter: RESET_VALUE, default 12'h000, value loaded into data_out on reset.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; one clock, synchronous, active-low (0 = reset asserted).
REQ-005 Port: data_in  input  12  data word to be captured.
REQ-006 Port: data_out  output  12  registered data word, driven directly from flops.
REQ-007 The port list SHALL contain exactly these four ports, so that instantiation by named connection (.data_in, .clk, .rst, .data_out) is complete.

Function
REQ-008 On each rising clk edge with rst=1, data_out SHALL take the value of data_in sampled at that edge.
REQ-009 Latency SHALL be exactly one clock: a change on data_in is visible on data_out only after the next rising edge.
REQ-010 data_out SHALL hold its value between rising edges regardless of data_in activity, including glitches and multiple changes.
REQ-011 No enable, handshake or bypass SHALL exist: every non-reset edge loads the register.
REQ-012 All 12 bits SHALL be captured independently; there is no arithmetic, no bit reordering and no truncation.
REQ-013 data_out SHALL be a pure register output with no combinational path from data_in or rst.
REQ-014 If rst and data_in both change before the same edge, rst takes priority: with rst=0, data_out becomes RESET_VALUE and data_in is ignored.

Reset
REQ-015 When rst=0 at a rising clk edge, data_out SHALL become RESET_VALUE (12'h000) after that edge.
REQ-016 Reset SHALL be synchronous only: asserting rst between edges SHALL NOT change data_out until the next rising edge.
REQ-017 Reset SHALL be honoured at any time; asserting it mid-stream discards the pending data_in at that edge.
REQ-018 On the first rising edge with rst=1 after reset, data_out SHALL load data_in normally; no extra recovery cycle is needed.
REQ-019 Before the first reset or load edge, data_out is undefined (X in simulation); no power-on initial value SHALL be relied upon.

Structure
REQ-020 A shared package SHALL hold the WIDTH default (12) and the RESET_VALUE default (12'h000) as named constants; no typedefs are required.
REQ-021 The block SHALL use one sub-module, dff_sync_rstn: a 1-bit flop with synchronous active-low reset and a reset-value parameter.
REQ-022 register_12bit SHALL instantiate dff_sync_rstn WIDTH times via a generate loop, with bit i of RESET_VALUE feeding instance i.
REQ-023 No latches and no asynchronous logic SHALL be inferred; all flops SHALL be on clk rising edge.

Verification
REQ-024 Reset: rst=0 and data_in=12'hFFF for one edge -> data_out=12'h000 after that edge.
REQ-025 Load: rst=1 and data_in=12'hA5C at an edge -> data_out=12'hA5C after the edge; data_out is unchanged before the edge.
REQ-026 Hold: data_in changes to 12'h123 and then 12'h456 between edges -> data_out keeps its old value until the edge, then becomes 12'h456.
REQ-027 Synchronous reset timing: rst drops to 0 mid-cycle while data_out=12'h7E1 -> data_out stays 12'h7E1 until the next rising edge, then becomes 12'h000.
REQ-028 Release: rst returns to 1 with data_in=12'h800 -> data_out=12'h800 on the first edge after release.
REQ-029 Random: 20 or more cycles of random data_in (low 12 bits used) and random rst -> at every edge, data_out equals (rst ? previous data_in : 12'h000); the bench compares automatically each cycle.
